// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared constants for the multicycle CPU controller: state encodings,
// opcode values, ALUOperation and ALUSrcB codes, the decoded control
// bundle and a helper that identifies the memory-wait states.
package cpu_ctrl_pkg;

    // State encodings (also the value seen on the debug state output)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    // Opcodes
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALUOperation codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

    // Decoded control bundle driven onto the datapath
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       ior_d;
        logic       alu_src_a;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
    } ctrl_t;

    // States that wait on the memory handshake
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts consecutive cycles spent in a memory-wait state with mem_ready low
// and flags a timeout when the count reaches TIMEOUT_CYCLES.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   in_wait      controller is currently in a memory-wait state
//   mem_ready    memory handshake
//   timeout      count == TIMEOUT_CYCLES while mem_ready is low
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int WAIT_CNT_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    // Outside wait states the count is held at zero, and every controller
    // transition into a wait state comes from a non-wait state or through
    // a mem_ready cycle, so the count is always zero on entry. A ready
    // cycle wins over the timeout because timeout requires mem_ready low.
    always_comb begin
        timeout = in_wait && !mem_ready && (cnt_q == LIMIT);
        cnt_d   = '0;
        if (in_wait && !mem_ready && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Moore control FSM for a multicycle CPU (ld, sd, R-type, beq).
// Optional feature macro: MEM_HANDSHAKE_EN. When defined, FETCH, MEMRD and
// MEMWR wait for mem_ready and abort to HALT (mem_err) after TIMEOUT_CYCLES
// idle cycles. When undefined, mem_ready is ignored and those states take
// one cycle each.
// Ports:
//   clk, reset           clock / asynchronous active-high reset
//   inputs[6:0]          opcode from the instruction register
//   zero                 ALU zero flag (branch condition)
//   mem_ready            memory handshake
//   PCWrite..PCSource    1-bit datapath controls
//   ALUSrcB, ALUOperation 2-bit datapath selects
//   state[3:0]           current state (debug)
//   retire               pulse in the last cycle of each instruction
//   illegal, mem_err     sticky abort causes
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int WAIT_CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] inputs,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOperation,
    output logic [3:0] state,
    output logic       retire,
    output logic       illegal,
    output logic       mem_err
);

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       mem_err_q, mem_err_d;
    logic       ready_eff;
    logic       timeout;
    ctrl_t      ctrl;

`ifdef MEM_HANDSHAKE_EN
    assign ready_eff = mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .WAIT_CNT_W     (WAIT_CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .in_wait   (is_wait_state(state_q)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );
`else
    assign ready_eff = 1'b1;
    assign timeout   = 1'b0;

    logic [WAIT_CNT_W-1:0] unused_limit;
    logic                  unused_in;
    assign unused_limit = WAIT_CNT_W'(TIMEOUT_CYCLES);
    assign unused_in    = mem_ready ^ (|unused_limit);
`endif

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        case (state_q)
            S_FETCH: begin
                if (ready_eff) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (inputs == OP_LD || inputs == OP_SD) begin
                    state_d = S_MEMADR;
                end else if (inputs == OP_R) begin
                    state_d = S_REXEC;
                end else if (inputs == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                if (inputs == OP_LD) begin
                    state_d = S_MEMRD;
                end else if (inputs == OP_SD) begin
                    state_d = S_MEMWR;
                end else begin
                    // Opcode changed under us; treat as illegal
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_MEMRD, S_MEMWR: begin
                if (ready_eff) begin
                    state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    // Output decode; reset forces every control low, even mid-instruction
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = ready_eff;
                ctrl.pc_write  = ready_eff;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SHL;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
                ctrl.retire    = ready_eff;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = 1'b1;
                ctrl.pc_write  = zero;
                ctrl.retire    = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (reset) begin
            ctrl = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign PCWrite      = ctrl.pc_write;
    assign IRWrite      = ctrl.ir_write;
    assign IorD         = ctrl.ior_d;
    assign ALUSrcA      = ctrl.alu_src_a;
    assign MemRead      = ctrl.mem_read;
    assign MemWrite     = ctrl.mem_write;
    assign MemtoReg     = ctrl.mem_to_reg;
    assign RegWrite     = ctrl.reg_write;
    assign PCSource     = ctrl.pc_source;
    assign ALUSrcB      = ctrl.alu_src_b;
    assign ALUOperation = ctrl.alu_op;
    assign retire       = ctrl.retire;
    assign state        = state_q;
    assign illegal      = illegal_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Self-checking bench for multicycle_control: a latency/vector table, a
// randomized instruction stream checked cycle by cycle against a
// per-instruction state-sequence model, and directed corner sequences
// (illegal opcode, memory timeout, asynchronous reset mid-store).
module tb_multicycle_control;

    localparam int ST_FETCH  = 0;
    localparam int ST_DECODE = 1;
    localparam int ST_MEMADR = 2;
    localparam int ST_MEMRD  = 3;
    localparam int ST_MEMWB  = 4;
    localparam int ST_MEMWR  = 5;
    localparam int ST_REXEC  = 6;
    localparam int ST_RWB    = 7;
    localparam int ST_BRANCH = 8;
    localparam int ST_HALT   = 9;

    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

`ifdef MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] inputs;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, IorD, ALUSrcA, MemRead, MemWrite;
    logic       MemtoReg, RegWrite, PCSource;
    logic [1:0] ALUSrcB, ALUOperation;
    logic [3:0] state;
    logic       retire, illegal, mem_err;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk          (clk),
        .reset        (reset),
        .inputs       (inputs),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .IRWrite      (IRWrite),
        .IorD         (IorD),
        .ALUSrcA      (ALUSrcA),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .PCSource     (PCSource),
        .ALUSrcB      (ALUSrcB),
        .ALUOperation (ALUOperation),
        .state        (state),
        .retire       (retire),
        .illegal      (illegal),
        .mem_err      (mem_err)
    );

    logic [13:0] act_ctrl;
    assign act_ctrl = {PCWrite, IRWrite, IorD, ALUSrcA, MemRead, MemWrite,
                       MemtoReg, RegWrite, PCSource, ALUSrcB, ALUOperation, retire};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected control vector for a state, from the per-state output rules.
    function automatic logic [13:0] exp_ctrl(input int st, input bit rdy, input bit z);
        bit pcw, irw, iord, srca, mrd, mwr, m2r, rw, pcs, ret;
        logic [1:0] srcb, aluop;
        {pcw, irw, iord, srca, mrd, mwr, m2r, rw, pcs, ret} = '0;
        srcb  = 2'b00;
        aluop = 2'b00;
        case (st)
            ST_FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            ST_DECODE: begin srcb = 2'b11; end
            ST_MEMADR: begin srca = 1; srcb = 2'b10; end
            ST_MEMRD:  begin mrd = 1; iord = 1; end
            ST_MEMWB:  begin rw = 1; m2r = 1; ret = 1; end
            ST_MEMWR:  begin mwr = 1; iord = 1; ret = rdy; end
            ST_REXEC:  begin srca = 1; aluop = 2'b10; end
            ST_RWB:    begin rw = 1; ret = 1; end
            ST_BRANCH: begin srca = 1; aluop = 2'b01; pcs = 1; pcw = z; ret = 1; end
            default:   ;
        endcase
        return {pcw, irw, iord, srca, mrd, mwr, m2r, rw, pcs, srcb, aluop, ret};
    endfunction

    typedef struct {
        int         st;
        bit         drv_rdy;
        bit         eff_rdy;
        bit         z;
        logic [6:0] op;
    } cyc_t;

    cyc_t exp_q[$];

    // Wait state held for w idle cycles, then one ready cycle. Without the
    // handshake the state lasts one cycle whatever mem_ready does.
    task automatic add_wait_phase(input int st, input int w, input logic [6:0] op, input bit z);
        bit drv;
        for (int i = 0; i < (HS ? w : 0); i++) exp_q.push_back('{st, 1'b0, 1'b0, z, op});
        drv = HS ? 1'b1 : 1'($urandom_range(0, 1));
        exp_q.push_back('{st, drv, 1'b1, z, op});
    endtask

    task automatic add_plain(input int st, input logic [6:0] op, input bit z);
        exp_q.push_back('{st, 1'($urandom_range(0, 1)), 1'b1, z, op});
    endtask

    task automatic build_instr(input logic [6:0] op, input bit z, input int wf, input int wm);
        add_wait_phase(ST_FETCH, wf, op, z);
        add_plain(ST_DECODE, op, z);
        case (op)
            OPC_LD:  begin add_plain(ST_MEMADR, op, z); add_wait_phase(ST_MEMRD, wm, op, z); add_plain(ST_MEMWB, op, z); end
            OPC_SD:  begin add_plain(ST_MEMADR, op, z); add_wait_phase(ST_MEMWR, wm, op, z); end
            OPC_R:   begin add_plain(ST_REXEC, op, z); add_plain(ST_RWB, op, z); end
            default: add_plain(ST_BRANCH, op, z);
        endcase
    endtask

    task automatic run_queue();
        cyc_t c;
        int   n = 0;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            inputs    = c.op;
            zero      = c.z;
            mem_ready = c.drv_rdy;
            @(negedge clk);
            check($sformatf("q_state[%0d]", n), 32'(state), 32'(c.st));
            check($sformatf("q_ctrl[%0d]", n), 32'(act_ctrl), 32'(exp_ctrl(c.st, c.eff_rdy, c.z)));
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Leaves the bench at posedge+1 of the first FETCH cycle.
    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        inputs    = OPC_R;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", 32'(state), 32'(ST_FETCH));
        check("rst_ctrl", 32'(act_ctrl), 32'h0);
        check("rst_flags", {30'h0, illegal, mem_err}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [6:0] op;
        bit         z;
        int         lat;
        int         pcw_cnt;
        int         rw_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc, pcw, rw, k, n;
        bit done;
        logic [6:0] ops[4];

        vecs[0] = '{OPC_LD,  1'b0, 5, 1, 1};
        vecs[1] = '{OPC_SD,  1'b0, 4, 1, 0};
        vecs[2] = '{OPC_R,   1'b0, 4, 1, 1};
        vecs[3] = '{OPC_BEQ, 1'b1, 3, 2, 0};
        vecs[4] = '{OPC_BEQ, 1'b0, 3, 1, 0};
        ops[0] = OPC_LD; ops[1] = OPC_SD; ops[2] = OPC_R; ops[3] = OPC_BEQ;

        do_reset();

        // Zero-wait latency table
        for (int v = 0; v < 5; v++) begin
            inputs = vecs[v].op; zero = vecs[v].z; mem_ready = 1'b1;
            cyc = 0; pcw = 0; rw = 0; done = 1'b0;
            for (k = 0; k < 20 && !done; k++) begin
                @(negedge clk);
                cyc++;
                pcw += int'(PCWrite);
                rw  += int'(RegWrite);
                if (retire) done = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check($sformatf("tbl_done[%0d]", v), 32'(done), 32'd1);
            check($sformatf("tbl_lat[%0d]", v), 32'(cyc), 32'(vecs[v].lat));
            check($sformatf("tbl_pcw[%0d]", v), 32'(pcw), 32'(vecs[v].pcw_cnt));
            check($sformatf("tbl_rw[%0d]", v), 32'(rw), 32'(vecs[v].rw_cnt));
            @(posedge clk); #1;
        end

        // Directed model sequences, then a random instruction stream
        do_reset();
        build_instr(OPC_R, 1'b0, 0, 0);
        build_instr(OPC_LD, 1'b0, 0, 3);
        build_instr(OPC_BEQ, 1'b1, 0, 0);
        build_instr(OPC_BEQ, 1'b0, 0, 0);
        build_instr(OPC_SD, 1'b0, 15, 15);
        for (int i = 0; i < 40; i++) begin
            build_instr(ops[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2),
                        $urandom_range(0, 3));
        end
        run_queue();

        // Illegal opcode
        inputs = OPC_BAD; mem_ready = 1'b1;
        @(negedge clk);
        check("ill_fetch", 32'(state), 32'(ST_FETCH));
        @(posedge clk); #1;
        @(negedge clk);
        check("ill_decode", 32'(state), 32'(ST_DECODE));
        check("ill_flag_early", 32'(illegal), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("ill_halt", 32'(state), 32'(ST_HALT));
            check("ill_flag", 32'(illegal), 32'd1);
            check("ill_ctrl", 32'(act_ctrl), 32'h0);
        end
        do_reset();
        @(negedge clk);
        check("ill_rst_state", 32'(state), 32'(ST_FETCH));
        check("ill_rst_flag", 32'(illegal), 32'd0);
        @(posedge clk); #1;

        // Memory timeout in FETCH
        do_reset();
        mem_ready = 1'b0;
        n = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (state != 4'(ST_FETCH)) break;
            n++;
            @(posedge clk); #1;
        end
`ifdef MEM_HANDSHAKE_EN
        check("to_cycles", 32'(n), 32'd16);
        check("to_state", 32'(state), 32'(ST_HALT));
        check("to_err", 32'(mem_err), 32'd1);
        check("to_ctrl", 32'(act_ctrl), 32'h0);
        // mem_ready on the 16th cycle wins over the timeout
        do_reset();
        mem_ready = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        mem_ready = 1'b1;
        @(negedge clk);
        check("late_state", 32'(state), 32'(ST_FETCH));
        check("late_irw", 32'(IRWrite), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("late_decode", 32'(state), 32'(ST_DECODE));
        check("late_err", 32'(mem_err), 32'd0);
`else
        check("nohs_cycles", 32'(n), 32'd1);
        check("nohs_state", 32'(state), 32'(ST_DECODE));
        check("nohs_err", 32'(mem_err), 32'd0);
`endif

        // Asynchronous reset while in MEMWR
        do_reset();
        inputs = OPC_SD; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = ~HS;
        #2;
        check("ar_pre_state", 32'(state), 32'(ST_MEMWR));
        check("ar_pre_mw", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("ar_mw", 32'(MemWrite), 32'd0);
        check("ar_ctrl", 32'(act_ctrl), 32'h0);
        @(negedge clk);
        check("ar_state", 32'(state), 32'(ST_FETCH));
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("ar_post_state", 32'(state), 32'(ST_FETCH));
        check("ar_post_rd", 32'(MemRead), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: number of consecutive cycles without mem_ready in a memory state before an abort.
REQ-002 Parameter WAIT_CNT_W, default 4: wait counter width; TIMEOUT_CYCLES SHALL fit in WAIT_CNT_W bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 inputs  in  7  opcode field from the instruction register, held stable by the datapath.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory handshake; the access completes in a cycle where this is high.
REQ-009 PCWrite, IRWrite, IorD, ALUSrcA, MemRead, MemWrite, MemtoReg, RegWrite, PCSource  out  1 each  datapath controls.
REQ-010 ALUSrcB  out  2  ALU B select: 00 register, 01 constant 4, 10 immediate, 11 shifted immediate.
REQ-011 ALUOperation  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
REQ-012 state  out  4  current state, for debug.
REQ-013 retire  out  1  one-cycle pulse when an instruction completes.
REQ-014 illegal, mem_err  out  1 each  sticky abort causes.

Function
REQ-015 The state machine SHALL be Moore; outputs decode from state, plus zero and mem_ready where noted; any output not listed for a state SHALL be 0.
REQ-016 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, HALT=9.
REQ-017 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOperation=00; when mem_ready=1 it SHALL also drive IRWrite=1 and PCWrite=1 and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-018 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOperation=00 and branch on opcode:
- 0000011 or 0100011 go to MEMADR.
- 0110011 goes to REXEC.
- 1100011 goes to BRANCH.
- Any other opcode goes to HALT with illegal set.
REQ-019 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOperation=00; opcode 0000011 goes to MEMRD, and 0100011 goes to MEMWR.
REQ-020 MEMRD SHALL drive MemRead=1, IorD=1; it SHALL go to MEMWB on mem_ready.
REQ-021 MEMWB SHALL drive RegWrite=1, MemtoReg=1, then go to FETCH.
REQ-022 MEMWR SHALL drive MemWrite=1, IorD=1; it SHALL go to FETCH on mem_ready.
REQ-023 REXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOperation=10, then go to RWB; RWB SHALL drive RegWrite=1, MemtoReg=0, then go to FETCH.
REQ-024 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOperation=01, PCSource=1, and PCWrite=zero, then go to FETCH.
REQ-025 HALT SHALL drive all datapath controls to 0 and SHALL remain in HALT until reset.
REQ-026 retire SHALL pulse in the cycle of each transition from MEMWB, MEMWR (on mem_ready), RWB or BRANCH into FETCH.
REQ-027 With zero wait states, latency SHALL be: ld 5 cycles, sd 4, R-type 4, beq 3.
REQ-028 The wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and whenever mem_ready=1, and SHALL increment each cycle in those states while mem_ready=0.
REQ-029 When the wait counter equals TIMEOUT_CYCLES with mem_ready=0, the next state SHALL be HALT with mem_err set.
REQ-030 mem_ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: the access completes and no abort occurs.

Reset
REQ-031 Asserting reset SHALL force state=FETCH, clear the wait counter, and clear illegal, mem_err and retire.
REQ-032 While reset is high, all control outputs SHALL be 0, including mid-instruction.
REQ-033 After reset deasserts, the first edge SHALL begin a FETCH.

Configuration
REQ-034 With macro MEM_HANDSHAKE_EN defined, REQ-017, REQ-020, REQ-022 and REQ-028 to REQ-030 SHALL apply as written.
REQ-035 Without MEM_HANDSHAKE_EN, mem_ready SHALL be ignored and treated as 1, the wait counter SHALL be omitted, mem_err SHALL be tied 0, and FETCH, MEMRD and MEMWR SHALL each take exactly one cycle.

Structure
REQ-036 Shared package cpu_ctrl_pkg SHALL hold the state encodings, the opcode constants (R, ld, sd, beq), the ALUOperation codes and the ALUSrcB codes.
REQ-037 The wait counter and timeout compare SHALL be a sub-module, mem_wait_timer.

Verification
REQ-038 Reset, then opcode 0110011 with mem_ready=1 throughout -> states 0,1,6,7,0; RegWrite=1 only in state 7; retire pulses once.
REQ-039 Opcode 0000011 with mem_ready low for 3 cycles in MEMRD -> MEMRD held for 4 cycles, then MEMWB with MemtoReg=1, RegWrite=1.
REQ-040 Opcode 1100011 with zero=1, then zero=0 -> PCWrite=1 in BRANCH the first time and 0 the second time; PCSource=1 both times.
REQ-041 Opcode 1111111 -> DECODE then HALT, illegal=1, all controls 0; reset returns the block to FETCH with illegal=0.
REQ-042 mem_ready held 0 in FETCH -> HALT after 16 cycles with mem_err=1; a repeat run with mem_ready=1 on the 16th cycle -> DECODE, no mem_err.
REQ-043 Reset asserted asynchronously during MEMWR -> MemWrite drops immediately, and state=0 on the next sampled cycle.
